demux1_4_buffered: RTL and testbench

//  Buffered 1-to-4 demultiplexer for the ALU datapath: the distributing counterpart of MUX4_1.
//  - Accepts one word per cycle on a valid/ready input.
//  - Steers each word to one of four output channels, chosen by S.
//  - Each channel has a one-entry holding register with its own valid/ready handshake.
//  - Feeds the four ALU result consumers from one shared producer.

---
 rtl/demux1_4_buffered_if.sv | 14 +
 rtl/demux1_4_buffered.sv | 55 +++++
 tb/tb_demux1_4_buffered.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/demux1_4_buffered_if.sv
// demux1_4_buffered_if: input handshake plus four buffered output channels of the 1-to-4 demux
interface demux1_4_buffered_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid, in_ready;
  logic [1:0] S;
  logic [WIDTH-1:0] D0, D1, D2, D3;
  logic v0, v1, v2, v3;
  logic r0, r1, r2, r3;
  logic [CNT_W-1:0] cnt;
  modport master(output in_data, in_valid, S, r0, r1, r2, r3,
                 input in_ready, D0, D1, D2, D3, v0, v1, v2, v3, cnt);
  modport slave(input in_data, in_valid, S, r0, r1, r2, r3,
                output in_ready, D0, D1, D2, D3, v0, v1, v2, v3, cnt);
endinterface

// File: rtl/demux1_4_buffered.sv
// demux1_4_buffered: steers each input word into one of four one-entry channel buffers.
// Define DEMUX_RR_EN to steer by an internal round-robin pointer instead of S.
module demux1_4_buffered #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  demux1_4_buffered_if.slave bus
);
  logic [WIDTH-1:0] d [4];
  logic [3:0] v, r;
  logic [1:0] dst;
  logic rdy, acc;
  logic [CNT_W-1:0] cnt;
  assign r = {bus.r3, bus.r2, bus.r1, bus.r0};
`ifdef DEMUX_RR_EN
  logic [1:0] ptr;
  // pointer only moves on accept, so a stalled channel keeps strict order
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else if (acc) ptr <= ptr + 2'd1;
  end
  assign dst = ptr;
`else
  assign dst = bus.S;
`endif
  assign rdy = ~v[dst] | r[dst];
  assign acc = bus.in_valid & rdy;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      d <= '{default: '0};
      cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && dst == 2'(i)) begin
          v[i] <= 1'b1;
          d[i] <= bus.in_data;
        end else if (r[i]) v[i] <= 1'b0;
      end
      cnt <= cnt + CNT_W'(acc);
    end
  end
  assign bus.in_ready = rdy;
  assign bus.cnt = cnt;
  assign bus.D0 = d[0];
  assign bus.D1 = d[1];
  assign bus.D2 = d[2];
  assign bus.D3 = d[3];
  assign bus.v0 = v[0];
  assign bus.v1 = v[1];
  assign bus.v2 = v[2];
  assign bus.v3 = v[3];
endmodule

// File: tb/tb_demux1_4_buffered.sv
// tb_demux1_4_buffered: random and directed stimulus against a per-channel queue model with a drain monitor
module tb_demux1_4_buffered;
  localparam int W = 8, C = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  demux1_4_buffered_if #(.WIDTH(W), .CNT_W(C)) bus();
  demux1_4_buffered #(.WIDTH(W), .CNT_W(C)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [W-1:0] q [4][$];
  int occ [4];
  logic [C-1:0] mcnt;
  logic [1:0] rrp, pdst;
  logic exp_rdy, pacc = 1'b0, prst = 1'b0, started = 1'b0;
  logic [3:0] pr, vv, rr;
  logic [W-1:0] dd [4];
  int total = 0, bad = 0;
  always_comb begin
    dd[0] = bus.D0; dd[1] = bus.D1; dd[2] = bus.D2; dd[3] = bus.D3;
    vv = {bus.v3, bus.v2, bus.v1, bus.v0};
    rr = {bus.r3, bus.r2, bus.r1, bus.r0};
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // one clock: retire the previous edge into the model, then drive the next inputs
  task automatic cyc(input logic rn, input logic vld, input logic [W-1:0] dat,
                     input logic [1:0] s, input logic [3:0] rv);
    logic [1:0] dst;
    @(posedge clk);
    if (!prst) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        occ[i] = 0;
      end
      mcnt = '0;
      rrp = '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (pacc && pdst == 2'(i)) occ[i] = 1;
        else if (pr[i]) occ[i] = 0;
      if (pacc) begin
        mcnt++;
        rrp++;
      end
    end
    #1;
    rst_n = rn; bus.in_valid = vld; bus.in_data = dat; bus.S = s;
    {bus.r3, bus.r2, bus.r1, bus.r0} = rv;
`ifdef DEMUX_RR_EN
    dst = rrp;
`else
    dst = s;
`endif
    exp_rdy = occ[dst] == 0 || rv[dst];
    pacc = rn && vld && exp_rdy;
    pdst = dst;
    pr = rv;
    prst = rn;
    if (pacc) q[dst].push_back(dat);
    started = 1'b1;
  endtask
  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("cnt", 32'(bus.cnt), 32'(mcnt));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("v%0d", i), 32'(vv[i]), 32'(occ[i] != 0));
        if (vv[i] && rr[i]) begin
          if (q[i].size() == 0) chk($sformatf("drain%0d_empty", i), 32'(1), 32'(0));
          else chk($sformatf("drain%0d", i), 32'(dd[i]), 32'(q[i].pop_front()));
        end
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.S = '0;
    {bus.r3, bus.r2, bus.r1, bus.r0} = 4'h0;
    cyc(0, 0, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    #1;
    chk("rst_v", 32'(vv), 32'(0));
    chk("rst_cnt", 32'(bus.cnt), 32'(0));
    chk("rst_rdy", 32'(bus.in_ready), 32'(1));
    for (int i = 0; i < 4; i++) chk("rst_d", 32'(dd[i]), 32'(0));
`ifndef DEMUX_RR_EN
    cyc(1, 1, 8'hA1, 2, 4'h0);
    cyc(1, 1, 8'hB2, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    #1;
    chk("steer_d2", 32'(bus.D2), 32'hA1);
    chk("steer_d0", 32'(bus.D0), 32'hB2);
    chk("steer_v", 32'(vv), 32'b0101);
    chk("steer_cnt", 32'(bus.cnt), 32'd2);
    cyc(1, 1, 8'h77, 1, 4'h0);
    cyc(1, 1, 8'h55, 1, 4'h0);
    #1 chk("bp_rdy", 32'(bus.in_ready), 32'(0));
    cyc(1, 1, 8'h55, 3, 4'h0);
    #1 chk("bp_other_rdy", 32'(bus.in_ready), 32'(1));
    cyc(1, 0, 0, 0, 4'h0);
    #1;
    chk("bp_d1", 32'(bus.D1), 32'h77);
    chk("bp_d3", 32'(bus.D3), 32'h55);
    chk("bp_cnt", 32'(bus.cnt), 32'd4);
    cyc(0, 0, 0, 0, 4'h0);
    for (int k = 0; k < 16; k++) begin
      cyc(1, 1, W'(k), 3, 4'b1000);
      #1 chk("tp_rdy", 32'(bus.in_ready), 32'(1));
    end
    cyc(1, 0, 0, 3, 4'b1000);
    #1;
    chk("tp_d3", 32'(bus.D3), 32'h0F);
    chk("tp_cnt", 32'(bus.cnt), 32'd16);
    for (int k = 0; k < 240; k++) cyc(1, 1, W'($urandom), 3, 4'b1000);
    cyc(1, 0, 0, 3, 4'b1000);
    #1 chk("wrap_cnt", 32'(bus.cnt), 32'd0);
    cyc(1, 1, 8'h5A, 2, 4'h0);
    cyc(0, 0, 0, 0, 4'h0);
    #1 chk("mid_v2_before", 32'(bus.v2), 32'(1));
    cyc(1, 0, 0, 0, 4'h0);
    #1 chk("mid_v2_after", 32'(bus.v2), 32'(0));
`else
    for (int k = 0; k < 5; k++) cyc(1, 1, W'(8'h10 + k), 0, 4'hF);
    cyc(1, 1, 8'h21, 0, 4'h0);
    cyc(1, 1, 8'h22, 0, 4'h0);
    cyc(1, 1, 8'h23, 0, 4'h0);
    cyc(1, 1, 8'h24, 0, 4'h0);
    #1 chk("rr_stall_rdy", 32'(bus.in_ready), 32'(0));
    cyc(1, 0, 0, 0, 4'hF);
`endif
    for (int k = 0; k < 3000; k++)
      cyc(($urandom % 100) != 0, ($urandom % 4) != 0, W'($urandom),
          2'($urandom), 4'($urandom));
    cyc(1, 0, 0, 0, 4'hF);
    cyc(1, 0, 0, 0, 4'hF);
    @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
